// File: rtl/branch_resolve.sv
// branch_resolve: resolves beq/bne/j descriptors against the fetch PC.
// A taken branch redirects pc to its target, pulses taken for one cycle,
// bumps a saturating taken counter and raises flush for FLUSH_CYCLES
// cycles. No new descriptor is accepted while the flush is in progress.
module branch_resolve #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [1:0]  br_op,
  input  logic        eq,
  input  logic [31:0] br_pc,
  input  logic [31:0] imm,
  input  logic [25:0] jtarget,
  output logic [31:0] pc,
  output logic        flush,
  output logic        taken,
  output logic [15:0] taken_cnt
);

  // FSM encoding
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  // Branch opcode encoding
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BEQ  = 2'b01;
  localparam logic [1:0] OP_BNE  = 2'b10;
  localparam logic [1:0] OP_J    = 2'b11;

  // The flush down-counter is 3 bits wide, so lengths above 7 cannot be held.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  logic [0:0]  state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] pc_reg, pc_next;
  logic        flush_reg, flush_next;
  logic        taken_reg, taken_next;
  logic [15:0] taken_cnt_reg, taken_cnt_next;

  logic        accept;
  logic        resolve_taken;
  logic        take;
  logic [31:0] link_pc;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] target;
  logic [31:0] seq_pc;

  // Handshake: descriptors are only taken while no flush is running.
  assign br_ready = (state_reg == IDLE);
  assign accept   = br_valid & br_ready;

  // Target arithmetic. All sums wrap modulo 2^32; there is no overflow flag.
  assign link_pc       = br_pc + 32'd4;
  assign branch_target = link_pc + (imm << 2);
  assign jump_target   = {link_pc[31:28], jtarget, 2'b00};
  assign target        = (br_op == OP_J) ? jump_target : branch_target;
  assign seq_pc        = pc_reg + 32'd4;

  // Decide whether the offered descriptor would redirect fetch.
  always_comb begin
    resolve_taken = 1'b0;
    case (br_op)
      OP_NONE: resolve_taken = 1'b0;
      OP_BEQ:  resolve_taken = eq;
      OP_BNE:  resolve_taken = ~eq;
      OP_J:    resolve_taken = 1'b1;
      default: resolve_taken = 1'b0;
    endcase
  end

  assign take = accept & resolve_taken;

  // Next fetch PC: a taken branch wins over stall, stall wins over +4.
  always_comb begin
    pc_next = seq_pc;
    if (take) begin
      pc_next = target;
    end else if (stall) begin
      pc_next = pc_reg;
    end
  end

  // Flush sequencing: load the counter on a taken accept, count down
  // every cycle in FLUSH (stall does not pause it), leave when it hits 0.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (take) begin
          state_next = FLUSH;
          cnt_next   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (cnt_reg <= 3'd1) begin
          state_next = IDLE;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 3'd0;
      end
    endcase
  end

  // Registered outputs derived from the next state and the accept decision.
  always_comb begin
    flush_next     = (state_next == FLUSH);
    taken_next     = take;
    taken_cnt_next = taken_cnt_reg;
    if (take && (taken_cnt_reg != CNT_MAX)) begin
      taken_cnt_next = taken_cnt_reg + 16'd1;
    end
  end

  // State update; reset beats every other input, including a taken accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 3'd0;
      pc_reg        <= RESET_PC;
      flush_reg     <= 1'b0;
      taken_reg     <= 1'b0;
      taken_cnt_reg <= 16'd0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      pc_reg        <= pc_next;
      flush_reg     <= flush_next;
      taken_reg     <= taken_next;
      taken_cnt_reg <= taken_cnt_next;
    end
  end

  assign pc        = pc_reg;
  assign flush     = flush_reg;
  assign taken     = taken_reg;
  assign taken_cnt = taken_cnt_reg;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve. Each test task builds a table of
// per-cycle stimulus with hand-derived expected outputs; the expectation is
// queued when the stimulus is driven and popped after the clock edge.
`timescale 1ns/1ps
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic        br_ready;
  logic [1:0]  br_op;
  logic        eq;
  logic [31:0] br_pc;
  logic [31:0] imm;
  logic [25:0] jtarget;
  logic [31:0] pc;
  logic        flush;
  logic        taken;
  logic [15:0] taken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve #(
    .RESET_PC    (32'h0000_0000),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .stall    (stall),
    .br_valid (br_valid),
    .br_ready (br_ready),
    .br_op    (br_op),
    .eq       (eq),
    .br_pc    (br_pc),
    .imm      (imm),
    .jtarget  (jtarget),
    .pc       (pc),
    .flush    (flush),
    .taken    (taken),
    .taken_cnt(taken_cnt)
  );

  // One cycle: inputs, then outputs expected after the next rising edge.
  typedef struct {
    string       name;
    logic        rst_n;
    logic        stall;
    logic        valid;
    logic [1:0]  op;
    logic        eq;
    logic [31:0] bpc;
    logic [31:0] imm;
    logic [25:0] jt;
    logic [31:0] pc;
    logic        flush;
    logic        taken;
    logic        ready;
    logic [15:0] cnt;
  } step_t;

  // Scoreboard entry: {pc, flush, taken, br_ready, taken_cnt}.
  typedef struct {
    string       name;
    logic [50:0] v;
  } exp_t;

  exp_t exp_q[$];

  task automatic apply(input step_t s);
    rst_n    = s.rst_n;
    stall    = s.stall;
    br_valid = s.valid;
    br_op    = s.op;
    eq       = s.eq;
    br_pc    = s.bpc;
    imm      = s.imm;
    jtarget  = s.jt;
    exp_q.push_back('{s.name, {s.pc, s.flush, s.taken, s.ready, s.cnt}});
  endtask

  task automatic test_reset();
    step_t tbl[$];
    exp_t  e;
    logic [50:0] obs;
    tbl.push_back('{"reset_hold", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h0, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{"reset_vs_jump", 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 32'hF000_0010, 32'h0, 26'h40,
                    32'h0, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{"seq_4", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h4, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{"seq_8", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h8, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{"seq_c", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'hC, 1'b0, 1'b0, 1'b1, 16'h0});
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {pc, flush, taken, br_ready, taken_cnt};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h flush=%b taken=%b ready=%b cnt=%h, expected pc=%h flush=%b taken=%b ready=%b cnt=%h",
                 e.name, pc, flush, taken, br_ready, taken_cnt, e.v[50:19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
      end else begin
        $display("ok   %s: pc=%h flush=%b taken=%b ready=%b cnt=%h", e.name, pc, flush, taken, br_ready, taken_cnt);
      end
    end
  endtask

  task automatic test_beq_taken();
    step_t tbl[$];
    exp_t  e;
    logic [50:0] obs;
    for (int k = 1; k <= 5; k++) begin
      tbl.push_back('{$sformatf("seq_%0h", 12 + 4 * k), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                      32'(12 + 4 * k), 1'b0, 1'b0, 1'b1, 16'h0});
    end
    tbl.push_back('{"beq_take", 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h1C, 32'hFFFF_FFFE, 26'h0,
                    32'h18, 1'b1, 1'b1, 1'b0, 16'h1});
    tbl.push_back('{"beq_flush2", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h1C, 1'b1, 1'b0, 1'b0, 16'h1});
    tbl.push_back('{"beq_done", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h20, 1'b0, 1'b0, 1'b1, 16'h1});
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {pc, flush, taken, br_ready, taken_cnt};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h flush=%b taken=%b ready=%b cnt=%h, expected pc=%h flush=%b taken=%b ready=%b cnt=%h",
                 e.name, pc, flush, taken, br_ready, taken_cnt, e.v[50:19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
      end else begin
        $display("ok   %s: pc=%h flush=%b taken=%b ready=%b cnt=%h", e.name, pc, flush, taken, br_ready, taken_cnt);
      end
    end
  endtask

  task automatic test_not_taken();
    step_t tbl[$];
    exp_t  e;
    logic [50:0] obs;
    tbl.push_back('{"bne_eq_stall", 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 32'h1C, 32'h10, 26'h0,
                    32'h20, 1'b0, 1'b0, 1'b1, 16'h1});
    tbl.push_back('{"beq_ne", 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h20, 32'h8, 26'h0,
                    32'h24, 1'b0, 1'b0, 1'b1, 16'h1});
    tbl.push_back('{"op_none", 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 32'h24, 32'h8, 26'h3F,
                    32'h28, 1'b0, 1'b0, 1'b1, 16'h1});
    tbl.push_back('{"stall_hold", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h28, 1'b0, 1'b0, 1'b1, 16'h1});
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {pc, flush, taken, br_ready, taken_cnt};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h flush=%b taken=%b ready=%b cnt=%h, expected pc=%h flush=%b taken=%b ready=%b cnt=%h",
                 e.name, pc, flush, taken, br_ready, taken_cnt, e.v[50:19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
      end else begin
        $display("ok   %s: pc=%h flush=%b taken=%b ready=%b cnt=%h", e.name, pc, flush, taken, br_ready, taken_cnt);
      end
    end
  endtask

  task automatic test_jump_stall();
    step_t tbl[$];
    exp_t  e;
    logic [50:0] obs;
    tbl.push_back('{"j_over_stall", 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'hF000_0010, 32'h0, 26'h40,
                    32'hF000_0100, 1'b1, 1'b1, 1'b0, 16'h2});
    tbl.push_back('{"j_refused_1", 1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 26'h10,
                    32'hF000_0100, 1'b1, 1'b0, 1'b0, 16'h2});
    tbl.push_back('{"j_refused_2", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 26'h10,
                    32'hF000_0104, 1'b0, 1'b0, 1'b1, 16'h2});
    tbl.push_back('{"j_after", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'hF000_0108, 1'b0, 1'b0, 1'b1, 16'h2});
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {pc, flush, taken, br_ready, taken_cnt};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h flush=%b taken=%b ready=%b cnt=%h, expected pc=%h flush=%b taken=%b ready=%b cnt=%h",
                 e.name, pc, flush, taken, br_ready, taken_cnt, e.v[50:19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
      end else begin
        $display("ok   %s: pc=%h flush=%b taken=%b ready=%b cnt=%h", e.name, pc, flush, taken, br_ready, taken_cnt);
      end
    end
  endtask

  task automatic test_wrap();
    step_t tbl[$];
    exp_t  e;
    logic [50:0] obs;
    tbl.push_back('{"j_to_top", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'hF000_0000, 32'h0, 26'h3FF_FFFF,
                    32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 16'h3});
    tbl.push_back('{"wrap_0", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h0, 1'b1, 1'b0, 1'b0, 16'h3});
    tbl.push_back('{"wrap_4", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h4, 1'b0, 1'b0, 1'b1, 16'h3});
    tbl.push_back('{"bne_back", 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'hFFFF_FFF0, 26'h0,
                    32'hFFFF_FFC8, 1'b1, 1'b1, 1'b0, 16'h4});
    tbl.push_back('{"flush_stall_1", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'hFFFF_FFC8, 1'b1, 1'b0, 1'b0, 16'h4});
    tbl.push_back('{"flush_stall_2", 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'hFFFF_FFC8, 1'b0, 1'b0, 1'b1, 16'h4});
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {pc, flush, taken, br_ready, taken_cnt};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h flush=%b taken=%b ready=%b cnt=%h, expected pc=%h flush=%b taken=%b ready=%b cnt=%h",
                 e.name, pc, flush, taken, br_ready, taken_cnt, e.v[50:19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
      end else begin
        $display("ok   %s: pc=%h flush=%b taken=%b ready=%b cnt=%h", e.name, pc, flush, taken, br_ready, taken_cnt);
      end
    end
  endtask

  // Counter preloaded near the top, then back-to-back taken jumps.
  task automatic test_back_to_back_saturate();
    step_t tbl[$];
    exp_t  e;
    logic [50:0] obs;
    force dut.taken_cnt_reg = 16'hFFFE;
    #1;
    release dut.taken_cnt_reg;
    for (int k = 0; k < 3; k++) begin
      tbl.push_back('{$sformatf("sat_take_%0d", k), 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 26'h10,
                      32'h40, 1'b1, 1'b1, 1'b0, 16'hFFFF});
      tbl.push_back('{$sformatf("sat_flush_%0d", k), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                      32'h44, 1'b1, 1'b0, 1'b0, 16'hFFFF});
      tbl.push_back('{$sformatf("sat_ready_%0d", k), 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                      32'h48, 1'b0, 1'b0, 1'b1, 16'hFFFF});
    end
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {pc, flush, taken, br_ready, taken_cnt};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h flush=%b taken=%b ready=%b cnt=%h, expected pc=%h flush=%b taken=%b ready=%b cnt=%h",
                 e.name, pc, flush, taken, br_ready, taken_cnt, e.v[50:19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
      end else begin
        $display("ok   %s: pc=%h flush=%b taken=%b ready=%b cnt=%h", e.name, pc, flush, taken, br_ready, taken_cnt);
      end
    end
  endtask

  task automatic test_reset_in_flush();
    step_t tbl[$];
    exp_t  e;
    logic [50:0] obs;
    tbl.push_back('{"rf_take", 1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 26'h10,
                    32'h40, 1'b1, 1'b1, 1'b0, 16'hFFFF});
    tbl.push_back('{"rf_reset", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h0, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{"rf_release", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h4, 1'b0, 1'b0, 1'b1, 16'h0});
    tbl.push_back('{"rf_beq_fwd", 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 32'h4, 32'h1, 26'h0,
                    32'hC, 1'b1, 1'b1, 1'b0, 16'h1});
    tbl.push_back('{"rf_flush2", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h10, 1'b1, 1'b0, 1'b0, 16'h1});
    tbl.push_back('{"rf_done", 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 26'h0,
                    32'h14, 1'b0, 1'b0, 1'b1, 16'h1});
    foreach (tbl[i]) begin
      apply(tbl[i]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      obs = {pc, flush, taken, br_ready, taken_cnt};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got pc=%h flush=%b taken=%b ready=%b cnt=%h, expected pc=%h flush=%b taken=%b ready=%b cnt=%h",
                 e.name, pc, flush, taken, br_ready, taken_cnt, e.v[50:19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
      end else begin
        $display("ok   %s: pc=%h flush=%b taken=%b ready=%b cnt=%h", e.name, pc, flush, taken, br_ready, taken_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_not_taken();
    test_jump_stall();
    test_wrap();
    test_back_to_back_saturate();
    test_reset_in_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
